data_mem_bridge: RTL and testbench

- Sits directly downstream of the core's data memory port.
- Converts byte/half/word load/store requests into word-aligned transfers on a valid/ready memory bus with byte enables.
- Splits accesses that cross a word boundary into two bus beats, and sign- or zero-extends load data.
- Stalls the core until the access completes or faults.

---
 rtl/data_mem_pkg.sv | 15 +
 rtl/data_mem_load_align.sv | 19 +
 rtl/data_mem_bridge.sv | 134 +++++++++++++
 tb/tb_data_mem_bridge.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: width codes, FSM encoding and lane helpers shared by the data memory bridge
package data_mem_pkg;
  localparam logic [2:0] WIDTH_B  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b001;
  localparam logic [2:0] WIDTH_W  = 3'b010;
  localparam logic [2:0] WIDTH_BU = 3'b100;
  localparam logic [2:0] WIDTH_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} state_e;
  function automatic logic [3:0] size_mask(input logic [1:0] w);
    return w == 2'b00 ? 4'b0001 : w == 2'b01 ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic crosses(input logic [1:0] w, input logic [1:0] off);
    return ({1'b0, off} + {1'b0, w[1], |w}) > 3'd3;
  endfunction
endpackage

// File: rtl/data_mem_load_align.sv
// data_mem_load_align: shifts the two captured bus words down to the access offset and extends the result
module data_mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  input  logic [1:0]  off,
  input  logic [2:0]  width,
  output logic [31:0] data
);
  logic [31:0] sh;
  always_comb begin
    sh = 32'({rd_hi, rd_lo} >> {off, 3'b000});
    data = width == WIDTH_B  ? {{24{sh[7]}}, sh[7:0]} :
           width == WIDTH_H  ? {{16{sh[15]}}, sh[15:0]} :
           width == WIDTH_BU ? {24'b0, sh[7:0]} :
           width == WIDTH_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: turns core byte/half/word loads and stores into word-aligned valid/ready bus beats
module data_mem_bridge
  import data_mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_write_data,
  input  logic [2:0]  data_mem_width,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  output logic [31:0] data_mem_data_fetched,
  output logic        data_mem_done,
  output logic        data_mem_stall,
  output logic        data_mem_fault,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_write,
  output logic        bus_valid,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d, ld_data;
  logic [2:0] width_q, width_d;
  logic write_q, write_d, fault_q, fault_d, req, illegal, beat1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] e8;
  logic [63:0] wd64;
  assign req = data_mem_read_enable | data_mem_write_enable;
  assign illegal = data_mem_width[1:0] == 2'b11 || data_mem_width[2:1] == 2'b11 ||
                   (data_mem_width[2] && data_mem_write_enable) ||
                   (data_mem_read_enable && data_mem_write_enable) ||
                   (!ALLOW_MISALIGNED && crosses(data_mem_width[1:0], data_mem_address[1:0]));
  assign e8 = {4'b0, size_mask(width_q[1:0])} << addr_q[1:0];
  assign wd64 = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign beat1 = state_q == S_BEAT1;
  data_mem_load_align u_align (
    .rd_lo(rd_lo_q),
    .rd_hi(rd_hi_q),
    .off  (addr_q[1:0]),
    .width(width_q),
    .data (ld_data)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    write_d = write_q;
    fault_d = fault_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    cnt_d = cnt_q;
    bus_valid = 1'b0;
    bus_write = 1'b0;
    bus_address = '0;
    bus_byte_enable = '0;
    bus_write_data = '0;
    data_mem_done = 1'b0;
    data_mem_fault = 1'b0;
    data_mem_stall = 1'b0;
    data_mem_data_fetched = '0;
    case (state_q)
      S_IDLE: begin
        data_mem_stall = reset & req;
        if (req) begin
          addr_d = data_mem_address;
          wdata_d = data_mem_write_data;
          width_d = data_mem_width;
          write_d = data_mem_write_enable;
          fault_d = illegal;
          cnt_d = '0;
          state_d = illegal ? S_DONE : S_BEAT0;
        end
      end
      S_BEAT0, S_BEAT1: begin
        data_mem_stall = 1'b1;
        bus_valid = 1'b1;
        bus_write = write_q;
        bus_address = {addr_q[31:2], 2'b00} + (beat1 ? 32'd4 : 32'd0);
        bus_byte_enable = beat1 ? e8[7:4] : e8[3:0];
        bus_write_data = beat1 ? wd64[63:32] : wd64[31:0];
        if (bus_ready) begin
          rd_lo_d = beat1 ? rd_lo_q : bus_read_data;
          rd_hi_d = beat1 ? bus_read_data : rd_hi_q;
          cnt_d = '0;
          state_d = !beat1 && |e8[7:4] ? S_BEAT1 : S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        data_mem_done = 1'b1;
        data_mem_fault = fault_q;
        data_mem_data_fetched = fault_q || write_q ? 32'b0 : ld_data;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      width_q <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      write_q <= write_d;
      fault_q <= fault_d;
      rd_lo_q <= rd_lo_d;
      rd_hi_q <= rd_hi_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed checks of beats, lanes, extension, timeout, faults and reset abort
module tb_data_mem_bridge;
  import data_mem_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] addr, wdata, rdata;
  logic [2:0] width;
  logic re, we, ready;
  logic [31:0] fetched, bus_address, bus_write_data;
  logic [3:0] be;
  logic done, stall, fault, bus_write, bus_valid;
  logic [31:0] na_fetched, na_bus_address, na_bus_write_data;
  logic [3:0] na_be;
  logic na_done, na_stall, na_fault, na_bus_write, na_bus_valid;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  data_mem_bridge #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .data_mem_address(addr), .data_mem_write_data(wdata), .data_mem_width(width),
    .data_mem_read_enable(re), .data_mem_write_enable(we),
    .data_mem_data_fetched(fetched), .data_mem_done(done), .data_mem_stall(stall), .data_mem_fault(fault),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_byte_enable(be),
    .bus_write(bus_write), .bus_valid(bus_valid), .bus_ready(ready), .bus_read_data(rdata)
  );
  data_mem_bridge #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(4)) dut_na (
    .clock(clock), .reset(reset),
    .data_mem_address(addr), .data_mem_write_data(wdata), .data_mem_width(width),
    .data_mem_read_enable(re), .data_mem_write_enable(we),
    .data_mem_data_fetched(na_fetched), .data_mem_done(na_done), .data_mem_stall(na_stall), .data_mem_fault(na_fault),
    .bus_address(na_bus_address), .bus_write_data(na_bus_write_data), .bus_byte_enable(na_be),
    .bus_write(na_bus_write), .bus_valid(na_bus_valid), .bus_ready(ready), .bus_read_data(rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [2:0] w, input logic r, input logic wr);
    @(negedge clock);
    addr = a;
    wdata = d;
    width = w;
    re = r;
    we = wr;
    #1;
    check({tag, " idle stall"}, 32'(stall), 32'd1);
    check({tag, " idle valid"}, 32'(bus_valid), 32'd0);
  endtask
  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic wr);
    @(negedge clock);
    #1;
    check({tag, " valid"}, 32'(bus_valid), 32'd1);
    check({tag, " addr"}, bus_address, a);
    check({tag, " be"}, 32'(be), 32'(b));
    check({tag, " wdata"}, bus_write_data, d);
    check({tag, " write"}, 32'(bus_write), 32'(wr));
    check({tag, " stall"}, 32'(stall), 32'd1);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask
  task automatic fin(input string tag, input logic [31:0] f, input logic flt);
    @(negedge clock);
    #1;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " fault"}, 32'(fault), 32'(flt));
    check({tag, " fetched"}, fetched, f);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " valid"}, 32'(bus_valid), 32'd0);
  endtask
  task automatic quiet(input int n);
    re = 1'b0;
    we = 1'b0;
    repeat (n) @(negedge clock);
  endtask
  task automatic all_zero(input string tag);
    check({tag, " valid"}, 32'(bus_valid), 32'd0);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " fault"}, 32'(fault), 32'd0);
    check({tag, " fetched"}, fetched, 32'd0);
    check({tag, " addr"}, bus_address, 32'd0);
    check({tag, " be"}, 32'(be), 32'd0);
    check({tag, " wdata"}, bus_write_data, 32'd0);
    check({tag, " write"}, 32'(bus_write), 32'd0);
  endtask
  initial begin
    addr = 0;
    wdata = 0;
    width = 0;
    re = 0;
    we = 0;
    ready = 0;
    rdata = 0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    all_zero("reset");
    reset = 1'b1;
    ready = 1'b1;
    rdata = 32'hDEADBEEF;
    issue("lw", 32'h100, 0, WIDTH_W, 1, 0);
    beat("lw b0", 32'h100, 4'b1111, 0, 0);
    fin("lw", 32'hDEADBEEF, 0);
    rdata = 32'h80123456;
    issue("lb", 32'h103, 0, WIDTH_B, 1, 0);
    beat("lb b0", 32'h100, 4'b1000, 0, 0);
    fin("lb", 32'hFFFFFF80, 0);
    issue("lbu", 32'h103, 0, WIDTH_BU, 1, 0);
    beat("lbu b0", 32'h100, 4'b1000, 0, 0);
    fin("lbu", 32'h00000080, 0);
    issue("sw", 32'h102, 32'h11223344, WIDTH_W, 0, 1);
    beat("sw b0", 32'h100, 4'b1100, 32'h33440000, 1);
    beat("sw b1", 32'h104, 4'b0011, 32'h00001122, 1);
    fin("sw", 0, 0);
    quiet(2);
    rdata = 32'hCD000000;
    issue("lh wrap", 32'hFFFFFFFF, 0, WIDTH_H, 1, 0);
    check("na stall", 32'(na_stall), 32'd1);
    beat("lh wrap b0", 32'hFFFFFFFC, 4'b1000, 0, 0);
    check("na done", 32'(na_done), 32'd1);
    check("na fault", 32'(na_fault), 32'd1);
    check("na valid", 32'(na_bus_valid), 32'd0);
    check("na fetched", na_fetched, 32'd0);
    beat("lh wrap b1", 32'h00000000, 4'b0001, 0, 0);
    rdata = 32'h000000AB;
    fin("lh wrap", 32'hFFFFABCD, 0);
    quiet(2);
    ready = 1'b0;
    issue("tmo", 32'h200, 0, WIDTH_W, 1, 0);
    for (int i = 0; i < 4; i++) beat("tmo wait", 32'h200, 4'b1111, 0, 0);
    fin("tmo", 0, 1);
    ready = 1'b1;
    rdata = 32'h12345678;
    issue("after tmo", 32'h300, 0, WIDTH_W, 1, 0);
    beat("after tmo b0", 32'h300, 4'b1111, 0, 0);
    fin("after tmo", 32'h12345678, 0);
    issue("illegal", 32'h400, 0, 3'b011, 1, 0);
    fin("illegal", 0, 1);
    rdata = 32'h0;
    issue("rst", 32'h101, 0, WIDTH_W, 1, 0);
    beat("rst b0", 32'h100, 4'b1110, 0, 0);
    beat("rst b1", 32'h104, 4'b0001, 0, 0);
    reset = 1'b0;
    #1;
    all_zero("rst async");
    @(negedge clock);
    #1;
    all_zero("rst held");
    re = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    #1;
    all_zero("rst release");
    rdata = 32'hCAFEF00D;
    issue("post rst", 32'h500, 0, WIDTH_W, 1, 0);
    beat("post rst b0", 32'h500, 4'b1111, 0, 0);
    fin("post rst", 32'hCAFEF00D, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
